// File: rtl/transmit.sv
// Serial transmitter for maze update words: each 16-bit word goes out MSB first
// as one SEN-framed burst of 16 SCLK pulses, followed by an idle gap.
module transmit #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [15:0] DATA_IN,
  input  logic        SEND,
  output logic        READY,
  output logic        DONE,
  output logic        SCLK,
  output logic        SDATA,
  output logic        SEN
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

  localparam logic [7:0] HALF_LOAD = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic [7:0]  count;
  logic [3:0]  bit_index;
  logic [15:0] shift_reg;
  logic        accept;

  // The last GAP cycle doubles as an accept point so a held SEND keeps SEN low
  // for exactly GAP_CYCLES between back-to-back frames.
  assign accept = SEND && ((state == IDLE) || ((state == GAP) && (count == 8'd0)));

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      count     <= 8'd0;
      bit_index <= 4'd0;
      shift_reg <= 16'd0;
      READY     <= 1'b1;
      DONE      <= 1'b0;
      SCLK      <= 1'b0;
      SDATA     <= 1'b0;
      SEN       <= 1'b0;
    end else if (accept) begin
      state     <= LOW;
      count     <= HALF_LOAD;
      bit_index <= 4'd15;
      shift_reg <= DATA_IN;
      READY     <= 1'b0;
      DONE      <= 1'b0;
      SCLK      <= 1'b0;
      SDATA     <= DATA_IN[15];
      SEN       <= 1'b1;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          READY <= 1'b1;
        end
        LOW: begin
          if (count == 8'd0) begin
            state <= HIGH;
            count <= HALF_LOAD;
            SCLK  <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end
        HIGH: begin
          if (count == 8'd0) begin
            SCLK  <= 1'b0;
            count <= HALF_LOAD;
            if (bit_index == 4'd0) begin
              state <= HOLD;
            end else begin
              // SDATA only moves on the falling SCLK edge, giving the receiver a full half-period of setup
              state     <= LOW;
              bit_index <= bit_index - 4'd1;
              shift_reg <= shift_reg << 1;
              SDATA     <= shift_reg[14];
            end
          end else begin
            count <= count - 8'd1;
          end
        end
        HOLD: begin
          if (count == 8'd0) begin
            state <= GAP;
            count <= GAP_LOAD;
            SEN   <= 1'b0;
            SDATA <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end
        GAP: begin
          if (count == 8'd0) begin
            state <= IDLE;
            READY <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          count <= 8'd0;
          READY <= 1'b1;
          SCLK  <= 1'b0;
          SDATA <= 1'b0;
          SEN   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmit.sv
// Bench for transmit: a receiver model per DUT rebuilds words from SCLK/SDATA/SEN
// and checks them against a queue of words pushed when each SEND is accepted.
module tb_transmit;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [15:0] data_a, data_b;
  logic        send_a, send_b;
  logic        ready_a, done_a, sclk_a, sdata_a, sen_a;
  logic        ready_b, done_b, sclk_b, sdata_b, sen_b;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];
  int          rise_cyc[$];
  int          sen_rise[$];
  int          sen_fall[$];
  int          done_cyc[$];
  bit          abort_a = 1'b0;

  logic        prev_sclk_a = 1'b0, prev_sen_a = 1'b0, prev_sdata_a = 1'b0;
  logic        prev_sclk_b = 1'b0, prev_sen_b = 1'b0;
  logic [15:0] rx_word_a = 16'd0, rx_word_b = 16'd0;
  int          rx_bits_a = 0, rx_bits_b = 0;
  logic [15:0] exp_a, exp_b;

  transmit #(.HALF_PERIOD(2), .GAP_CYCLES(4)) dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .DATA_IN(data_a), .SEND(send_a),
    .READY(ready_a), .DONE(done_a), .SCLK(sclk_a), .SDATA(sdata_a), .SEN(sen_a)
  );

  transmit #(.HALF_PERIOD(1), .GAP_CYCLES(1)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .DATA_IN(data_b), .SEND(send_b),
    .READY(ready_b), .DONE(done_b), .SCLK(sclk_b), .SDATA(sdata_b), .SEN(sen_b)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc++;

  // Receiver model for DUT A, with frame-level timing logs for the directed tests
  always @(negedge CLOCK) begin
    if (sen_a === 1'b1 && sclk_a === 1'b1 && prev_sclk_a === 1'b0) begin
      rx_word_a = {rx_word_a[14:0], sdata_a};
      rx_bits_a++;
      rise_cyc.push_back(cyc);
    end
    if (sclk_a === 1'b1) begin
      vectors++;
      if (sen_a !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL sclk_without_sen at cyc %0d: sen=%b, required 1", cyc, sen_a);
      end
    end
    if (sclk_a === 1'b1 && prev_sclk_a === 1'b1) begin
      vectors++;
      if (sdata_a !== prev_sdata_a) begin
        miscompares++;
        $display("[TB] FAIL sdata_stable_high at cyc %0d: sdata=%b, required %b", cyc, sdata_a, prev_sdata_a);
      end
    end
    if (sen_a === 1'b1 && prev_sen_a === 1'b0) sen_rise.push_back(cyc);
    if (sen_a === 1'b0 && prev_sen_a === 1'b1) begin
      sen_fall.push_back(cyc);
      vectors++;
      if (abort_a) begin
        abort_a = 1'b0;
        if (rx_bits_a >= 16) begin
          miscompares++;
          $display("[TB] FAIL abort_partial: bits=%0d, required fewer than 16", rx_bits_a);
        end
      end else if (sb_a.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_frame_a: word=%h, required no frame", rx_word_a);
      end else begin
        exp_a = sb_a.pop_front();
        if (rx_bits_a != 16 || rx_word_a !== exp_a) begin
          miscompares++;
          $display("[TB] FAIL rx_word_a: got %h (%0d bits), required %h (16 bits)", rx_word_a, rx_bits_a, exp_a);
        end
      end
      rx_word_a = 16'd0;
      rx_bits_a = 0;
    end
    if (done_a === 1'b1) done_cyc.push_back(cyc);
    prev_sclk_a  = sclk_a;
    prev_sen_a   = sen_a;
    prev_sdata_a = sdata_a;
  end

  // Receiver model for DUT B
  always @(negedge CLOCK) begin
    if (sen_b === 1'b1 && sclk_b === 1'b1 && prev_sclk_b === 1'b0) begin
      rx_word_b = {rx_word_b[14:0], sdata_b};
      rx_bits_b++;
    end
    if (sen_b === 1'b0 && prev_sen_b === 1'b1) begin
      vectors++;
      if (sb_b.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_frame_b: word=%h, required no frame", rx_word_b);
      end else begin
        exp_b = sb_b.pop_front();
        if (rx_bits_b != 16 || rx_word_b !== exp_b) begin
          miscompares++;
          $display("[TB] FAIL rx_word_b: got %h (%0d bits), required %h (16 bits)", rx_word_b, rx_bits_b, exp_b);
        end
      end
      rx_word_b = 16'd0;
      rx_bits_b = 0;
    end
    prev_sclk_b = sclk_b;
    prev_sen_b  = sen_b;
  end

  task automatic clear_logs();
    rise_cyc.delete();
    sen_rise.delete();
    sen_fall.delete();
    done_cyc.delete();
  endtask

  task automatic wait_ready_a(input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK);
      if (ready_a === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_a_timeout: ready=%b after %0d cycles, required 1", ready_a, budget);
    end
  endtask

  task automatic wait_ready_b(input int budget);
    int seen;
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK);
      if (ready_b === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_b_timeout: ready=%b after %0d cycles, required 1", ready_b, budget);
    end
  endtask

  task automatic send_a_word(input logic [15:0] word, output int t0);
    int dummy;
    wait_ready_a(200, dummy);
    data_a = word;
    send_a = 1'b1;
    @(negedge CLOCK);
    send_a = 1'b0;
    t0 = cyc;
    sb_a.push_back(word);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    vectors++;
    if ({ready_a, done_a, sclk_a, sdata_a, sen_a} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL reset_state_a: got %b, required 10000", {ready_a, done_a, sclk_a, sdata_a, sen_a});
    end
    vectors++;
    if ({ready_b, done_b, sclk_b, sdata_b, sen_b} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL reset_state_b: got %b, required 10000", {ready_b, done_b, sclk_b, sdata_b, sen_b});
    end
    RESET = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic test_single_frame();
    int t0, ready_at;
    clear_logs();
    send_a_word(16'hA5C3, t0);
    wait_ready_a(200, ready_at);
    vectors++;
    if (ready_at - t0 != 70) begin
      miscompares++;
      $display("[TB] FAIL ready_time: got %0d, required 70", ready_at - t0);
    end
    vectors++;
    if (rise_cyc.size() != 16) begin
      miscompares++;
      $display("[TB] FAIL sclk_rise_count: got %0d, required 16", rise_cyc.size());
    end
    for (int k = 0; k < 16 && k < rise_cyc.size(); k++) begin
      vectors++;
      if (rise_cyc[k] - t0 != 2 * (2 * k + 1)) begin
        miscompares++;
        $display("[TB] FAIL sclk_rise_%0d: got t=%0d, required t=%0d", k, rise_cyc[k] - t0, 2 * (2 * k + 1));
      end
    end
    vectors++;
    if (sen_fall.size() != 1 || sen_fall[0] - t0 != 66) begin
      miscompares++;
      $display("[TB] FAIL sen_fall_time: got t=%0d (count %0d), required t=66",
               sen_fall.size() > 0 ? sen_fall[0] - t0 : -1, sen_fall.size());
    end
    vectors++;
    if (done_cyc.size() != 1 || done_cyc[0] - t0 != 66) begin
      miscompares++;
      $display("[TB] FAIL done_pulse: got t=%0d (count %0d), required single pulse at t=66",
               done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, done_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, dummy, guard;
    clear_logs();
    wait_ready_a(200, dummy);
    data_a = 16'h1234;
    send_a = 1'b1;
    @(negedge CLOCK);
    t0 = cyc;
    sb_a.push_back(16'h1234);
    data_a = 16'hFFFF;
    sb_a.push_back(16'hFFFF);
    guard = 0;
    while (sen_rise.size() < 2 && guard < 200) begin
      @(negedge CLOCK);
      guard++;
    end
    send_a = 1'b0;
    vectors++;
    if (sen_rise.size() < 2 || sen_fall.size() < 1) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_frame: rises=%0d falls=%0d, required 2 and 1", sen_rise.size(), sen_fall.size());
    end else begin
      vectors++;
      if (sen_rise[1] - t0 != 70) begin
        miscompares++;
        $display("[TB] FAIL b2b_accept_time: got t=%0d, required t=70", sen_rise[1] - t0);
      end
      vectors++;
      if (sen_rise[1] - sen_fall[0] != 4) begin
        miscompares++;
        $display("[TB] FAIL b2b_gap: got %0d cycles, required 4", sen_rise[1] - sen_fall[0]);
      end
    end
    wait_ready_a(300, dummy);
    vectors++;
    if (done_cyc.size() != 2 || sb_a.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_frames_done: done=%0d pending=%0d, required 2 and 0", done_cyc.size(), sb_a.size());
    end
  endtask

  task automatic test_ignore_midframe();
    int t0, dummy;
    clear_logs();
    send_a_word(16'hBEEF, t0);
    repeat (10) @(negedge CLOCK);
    data_a = 16'h0000;
    send_a = 1'b1;
    @(negedge CLOCK);
    send_a = 1'b0;
    wait_ready_a(200, dummy);
    repeat (4) @(negedge CLOCK);
    vectors++;
    if (sen_rise.size() != 1 || sen_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midframe_send_ignored: frames=%0d sen=%b, required 1 and 0", sen_rise.size(), sen_a);
    end
  endtask

  task automatic test_abort();
    int t0, t1, ready_at;
    clear_logs();
    send_a_word(16'h5A5A, t0);
    repeat (20) @(negedge CLOCK);
    RESET = 1'b1;
    abort_a = 1'b1;
    void'(sb_a.pop_back());
    @(negedge CLOCK);
    RESET = 1'b0;
    vectors++;
    if ({sen_a, sclk_a, sdata_a, ready_a, done_a} !== 5'b00010) begin
      miscompares++;
      $display("[TB] FAIL abort_state: got %b, required 00010", {sen_a, sclk_a, sdata_a, ready_a, done_a});
    end
    data_a = 16'h3C96;
    send_a = 1'b1;
    @(negedge CLOCK);
    send_a = 1'b0;
    t1 = cyc;
    sb_a.push_back(16'h3C96);
    wait_ready_a(200, ready_at);
    vectors++;
    if (ready_at - t1 != 70) begin
      miscompares++;
      $display("[TB] FAIL post_abort_ready: got t=%0d, required t=70", ready_at - t1);
    end
    vectors++;
    if (done_cyc.size() != 1 || done_cyc[0] - t1 != 66) begin
      miscompares++;
      $display("[TB] FAIL abort_done: got count %0d, required single DONE at t=66 of new frame", done_cyc.size());
    end
  endtask

  task automatic test_reset_priority();
    int dummy;
    wait_ready_a(200, dummy);
    RESET  = 1'b1;
    send_a = 1'b1;
    data_a = 16'hFFFF;
    @(negedge CLOCK);
    RESET  = 1'b0;
    send_a = 1'b0;
    vectors++;
    if (sen_a !== 1'b0 || ready_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_priority: sen=%b ready=%b, required 0 and 1", sen_a, ready_a);
    end
    @(negedge CLOCK);
    vectors++;
    if (sen_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_priority_late: sen=%b, required 0", sen_a);
    end
  endtask

  task automatic test_min_timing();
    logic [15:0] bits;
    logic        prev;
    int          rises[$];
    int          fall_at, ready_at;
    bits     = 16'd0;
    prev     = 1'b0;
    fall_at  = -1;
    ready_at = -1;
    wait_ready_b(100);
    data_b = 16'h8001;
    send_b = 1'b1;
    @(negedge CLOCK);
    send_b = 1'b0;
    sb_b.push_back(16'h8001);
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLOCK);
      if (sclk_b === 1'b1 && prev === 1'b0) begin
        rises.push_back(c);
        bits = {bits[14:0], sdata_b};
      end
      if (sen_b === 1'b0 && fall_at < 0) fall_at = c;
      if (ready_b === 1'b1 && ready_at < 0) ready_at = c;
      prev = sclk_b;
    end
    vectors++;
    if (rises.size() != 16) begin
      miscompares++;
      $display("[TB] FAIL min_rise_count: got %0d, required 16", rises.size());
    end
    for (int k = 0; k < 16 && k < rises.size(); k++) begin
      vectors++;
      if (rises[k] != 2 * k + 1) begin
        miscompares++;
        $display("[TB] FAIL min_rise_%0d: got t=%0d, required t=%0d", k, rises[k], 2 * k + 1);
      end
    end
    vectors++;
    if (bits !== 16'h8001) begin
      miscompares++;
      $display("[TB] FAIL min_bits: got %h, required 8001", bits);
    end
    vectors++;
    if (fall_at != 33 || ready_at != 34) begin
      miscompares++;
      $display("[TB] FAIL min_end_timing: sen fall t=%0d ready t=%0d, required 33 and 34", fall_at, ready_at);
    end
  endtask

  task automatic test_random();
    int guard;
    for (int i = 0; i < 1000; i++) begin
      wait_ready_b(100);
      data_b = 16'($urandom);
      send_b = 1'b1;
      @(negedge CLOCK);
      send_b = 1'b0;
      sb_b.push_back(data_b);
    end
    guard = 0;
    while (sb_b.size() != 0 && guard < 100) begin
      @(negedge CLOCK);
      guard++;
    end
    vectors++;
    if (sb_b.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL random_drain: %0d words pending, required 0", sb_b.size());
    end
  endtask

  initial begin
    RESET  = 1'b1;
    send_a = 1'b0;
    send_b = 1'b0;
    data_a = 16'd0;
    data_b = 16'd0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_midframe();
    test_abort();
    test_reset_priority();
    test_min_timing();
    test_random();
    repeat (2) @(negedge CLOCK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/transmit.md
TRANSMIT -- requirements
Module: transmit

Interface
REQ-001 Parameter HALF_PERIOD, default 4: CLOCK cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 8: idle CLOCK cycles with SEN low between frames; legal range 1..255.
REQ-003 CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  reset, synchronous and active-high.
REQ-005 DATA_IN  input  16  maze update word: [15:14] x, [13:11] y, [10:8] square state, [7:4] walls N/E/S/W, [3:0] reserved.
REQ-006 SEND  input  1  request to transmit DATA_IN; accepted only when READY=1.
REQ-007 READY  output  1  high only in IDLE; the transmitter can accept a word.
REQ-008 DONE  output  1  one-cycle pulse when a frame completes.
REQ-009 SCLK  output  1  serial clock to the receiver; the receiver samples SDATA on its rising edge.
REQ-010 SDATA  output  1  serial data, MSB first.
REQ-011 SEN  output  1  frame enable; high for the whole frame.

Function
REQ-012 All outputs shall be registered, with no combinational path from any input to any output.
REQ-013 States: IDLE, LOW, HIGH, HOLD, GAP.
REQ-014 IDLE: READY=1, SEN=0, SCLK=0, SDATA=0, DONE=0.
REQ-015 On an edge with IDLE and SEND=1, the block shall latch DATA_IN into a 16-bit shift register, set SEN=1, set SDATA=DATA_IN[15], set SCLK=0 and READY=0, and enter LOW with bit index 15. This edge is the acceptance edge, t=0.
REQ-016 LOW lasts HALF_PERIOD cycles with SCLK=0, then the block enters HIGH with SCLK=1 and SDATA unchanged.
REQ-017 HIGH lasts HALF_PERIOD cycles.
  - On exit with bit index >0: SCLK=0, SDATA=next lower bit, index decremented, return to LOW.
  - On exit with index 0: SCLK=0, enter HOLD.
REQ-018 SDATA shall change only on edges where SCLK goes low or at the acceptance edge, never while SCLK=1.
REQ-019 Timing: SCLK rise k (k=0..15) at t=HALF_PERIOD*(2k+1).
REQ-020 HOLD lasts HALF_PERIOD cycles with SEN=1 and SCLK=0.
  - On exit: SEN=0, SDATA=0, DONE=1 for exactly one cycle, enter GAP.
  - SEN therefore falls at t=33*HALF_PERIOD.
REQ-021 GAP lasts GAP_CYCLES cycles, then the block enters IDLE with READY=1 at t=33*HALF_PERIOD+GAP_CYCLES.
REQ-022 SEND and DATA_IN shall be ignored in every state except IDLE. Changes to DATA_IN mid-frame shall not affect transmitted bits.
REQ-023 SEND held continuously high shall give back-to-back frames, with SEN low for exactly GAP_CYCLES between them.
REQ-024 The half-period counter shall be wide enough for HALF_PERIOD and GAP_CYCLES, shall reload on every state change, and shall never wrap.
REQ-025 Exactly 16 SCLK rising edges shall occur per frame. SCLK shall stay 0 whenever SEN=0.

Reset
REQ-026 While RESET=1 at an edge, the block shall go to IDLE: READY=1, DONE=0, SEN=0, SCLK=0, SDATA=0, counters and shift register cleared.
REQ-027 RESET mid-frame shall abort the frame at the next edge, dropping SEN with no further SCLK edges and no DONE pulse. The receiver discards the partial word.
REQ-028 RESET has priority over a simultaneous SEND. A SEND on the first edge after RESET deasserts shall be accepted.

Verification (HALF_PERIOD=2, GAP_CYCLES=4)
REQ-029 Send 16'hA5C3 -> SDATA sampled at SCLK rises (t=2,6,...,62) reads 1010010111000011; SEN falls at t=66; DONE high at t=66 only; READY=1 at t=70.
REQ-030 SEND held high with DATA_IN 16'h1234 then 16'hFFFF -> frames accepted at t=0 and t=70; SEN low exactly 4 cycles; second frame all ones.
REQ-031 DATA_IN changed to 16'h0000 and SEND pulsed at t=10 during a frame of 16'hBEEF -> received word 16'hBEEF; no second frame starts.
REQ-032 RESET asserted at t=20 for one cycle -> at t=21 SEN=0, SCLK=0, SDATA=0, READY=1; no DONE; a new SEND at t=21 yields a full correct frame.
REQ-033 HALF_PERIOD=1, GAP_CYCLES=1, send 16'h8001 -> SCLK rises at t=1,3,...,31; SEN falls at t=33; READY at t=34; first and last sampled bits are 1, all others 0.
REQ-034 A self-check bench shall loop transmit into the existing receiver over SCLK/SDATA/SEN for 1000 random words, and every received 16-bit word shall equal the sent word.
